ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Receive-side counterpart to the ws2812 LED driver. It decodes a WS2812 single-wire NRZ pulse stream into 24-bit pixel words, each tagged with its LED index.
- Used for loopback self-test of the neopixel output on the icesugar board (neopixel_pin wired back to a spare input). It also serves as the checker inside the ws2812 testbench.
- Output format matches the driver's write-side port: rgb_data[23:0] plus an 8-bit led_num, so captured words can be compared directly with what was written.

Parameters:
- NUM_LEDS, 7: number of pixels per frame. Words beyond this count flag overflow instead of producing pixel_valid.
- BIT_SPLIT, 8: high-pulse width threshold in clk cycles. Width ≥ BIT_SPLIT decodes as 1; otherwise 0. The default gives 667 ns at 12 MHz.
- MIN_HIGH, 2: shortest legal high pulse in cycles. Shorter pulses are glitches.
- MAX_HIGH, 18: longest legal high pulse in cycles (1.5 µs at 12 MHz).
- RESET_LOW, 600: low time in cycles (50 µs at 12 MHz) that marks a frame boundary / latch.

Ports:
- clk  in  1  system clock (CLK on icesugar, 12 MHz).
- reset  in  1  asynchronous, active-high reset.
- din  in  1  WS2812 serial data. Asynchronous to clk; synchronised internally.
- rgb_data  out  24  last completed word. The first bit received is bit 23.
- led_num  out  8  index of the word in rgb_data, 0-based within the frame.
- pixel_valid  out  1  one-cycle pulse: rgb_data/led_num updated, and led_num < NUM_LEDS.
- overflow  out  1  one-cycle pulse: a complete word was received with index ≥ NUM_LEDS.
- frame_done  out  1  one-cycle pulse when a RESET_LOW gap ends a frame.
- err  out  1  one-cycle pulse on any protocol violation.

Behaviour:
- Reset values: rgb_data=0, led_num=0, all pulse outputs 0, state SYNC, bit_cnt=0, word counter=0, shift register=0.
- Synchronisation: two-flop synchroniser din→din_s, plus a delayed copy for edge detection.
  - All widths below are counted in cycles of din_s.
  - Output latency is exactly 3 clk cycles: the pulse asserts on the 3rd rising clk edge after the din edge that completes the event.
- Width counters saturate at RESET_LOW. Counter width is $clog2(RESET_LOW+1).
- SYNC state:
  - Ignores data and waits for din_s low for RESET_LOW consecutive cycles, then moves to IDLE. No frame_done is issued.
  - Any high resets the low counter.
- IDLE state:
  - Line is low and the word counter is 0.
  - A rising edge starts a frame and moves to HIGH with the width counter set to 1.
- HIGH state (counts high cycles W):
  - Falling edge with MIN_HIGH ≤ W ≤ MAX_HIGH:
    - Shift bit (W ≥ BIT_SPLIT) into the LSB and increment bit_cnt.
    - Move to LOW.
    - If bit_cnt reaches 24: load rgb_data, set led_num to the word counter, pulse pixel_valid (or overflow if word counter ≥ NUM_LEDS), increment the word counter (saturating at 255), and clear bit_cnt.
  - Falling edge with W < MIN_HIGH: pulse err, clear bit_cnt and word counter, go to SYNC.
  - W reaching MAX_HIGH+1 while still high (stuck high): pulse err once, go to SYNC. Nothing more is decoded until a RESET_LOW gap.
- LOW state:
  - Rising edge: go to HIGH. The low width between bits is otherwise unchecked.
  - Low count reaching RESET_LOW:
    - Pulse frame_done.
    - If bit_cnt ≠ 0, pulse err in the same cycle (partial word discarded).
    - Clear bit_cnt and word counter, go to IDLE.
- rgb_data and led_num hold their values until the next completed word. They are not cleared by frame_done.
- Simultaneous events: a word completion and frame_done never coincide. A glitch error takes precedence over decoding.
- Reset mid-operation: immediate return to reset values; the partial word is lost and no pulses are emitted.

Decomposition:
- Shared package ws2812_pkg:
  - WS2812 timing constants in ns (T0H 400, T1H 800, TRESET 50000).
  - A function converting ns to cycles for a given CLK_HZ.
  - The state enum {SYNC, IDLE, HIGH, LOW}.
  - The ws2812 driver and ws2812_rx both take their defaults from it.
- One natural sub-module, pulse_width_meter: synchroniser, edge detect and saturating high/low counters. It outputs the rise/fall strobes with the measured width.
- The FSM and word assembly stay in ws2812_rx.

Test Plan:
- Initial gap of 600 low cycles, then 24 bits of 0xA53C0F (1 = 10 high/5 low cycles, 0 = 5 high/10 low), then 600 low → pixel_valid once, rgb_data=0xA53C0F, led_num=0, then frame_done; err never asserts.
- 7 words 0x000001..0x000007 + gap, then an 8th word in a second frame → 7 pixel_valid pulses with led_num 0..6 and correct data, frame_done; led_num restarts at 0 in the second frame.
- 8 words in one frame with NUM_LEDS=7 → 7 pixel_valid pulses, 1 overflow pulse with led_num=7, rgb_data = 8th word.
- Threshold boundary: bits with W=7 and W=8 → decoded as 0 and 1 respectively. W=1 → err, following bits ignored until a 600-cycle gap.
- 10 bits then a 600-cycle low → frame_done and err in the same cycle, no pixel_valid; the next frame decodes normally.
- din held high for 40 cycles → exactly one err pulse. Also assert reset mid-word (bit 12), then run a full frame → word decoded with led_num=0, no stale bits.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants, ns-to-cycle helper and receiver state encoding.
// Pure declarations: no latency, no backpressure.
package ws2812_pkg;

    localparam int unsigned T0H_NS      = 400;
    localparam int unsigned T1H_NS      = 800;
    localparam int unsigned TRESET_NS   = 50000;
    localparam int unsigned MIN_HIGH_NS = 167;
    localparam int unsigned SPLIT_NS    = 667;
    localparam int unsigned MAX_HIGH_NS = 1500;
    localparam int unsigned DEF_CLK_HZ  = 12_000_000;

    // Truncating conversion; 64-bit product avoids overflow at MHz clocks.
    function automatic int unsigned ns_to_cycles(input int unsigned ns, input int unsigned clk_hz);
        logic [63:0] prod;
        prod = (64'(ns) * 64'(clk_hz)) / 64'd1_000_000_000;
        return 32'(prod);
    endfunction

    localparam int unsigned DEF_NUM_LEDS  = 7;
    localparam int unsigned DEF_MIN_HIGH  = ns_to_cycles(MIN_HIGH_NS, DEF_CLK_HZ);
    localparam int unsigned DEF_BIT_SPLIT = ns_to_cycles(SPLIT_NS, DEF_CLK_HZ);
    localparam int unsigned DEF_MAX_HIGH  = ns_to_cycles(MAX_HIGH_NS, DEF_CLK_HZ);
    localparam int unsigned DEF_RESET_LOW = ns_to_cycles(TRESET_NS, DEF_CLK_HZ);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_e;

endpackage

// File: rtl/pulse_width_meter.sv
// Synchronises din, detects edges and measures run lengths of the synchronised level.
// Strobes valid 2 cycles after the din edge; no backpressure.
module pulse_width_meter #(
    parameter int unsigned SAT = 600,
    parameter int unsigned CW  = $clog2(SAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din_i,
    output logic          level_o,
    output logic          rise_o,
    output logic          fall_o,
    output logic [CW-1:0] width_o,
    output logic [CW-1:0] run_o
);

    localparam logic [CW-1:0] SAT_C = CW'(SAT);

    logic          sync1_q;
    logic          din_s_q;
    logic          din_d_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            din_s_q <= 1'b0;
            din_d_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            din_s_q <= sync1_q;
            din_d_q <= din_s_q;
            cnt_q   <= run_o;
        end
    end

    assign level_o = din_s_q;
    assign rise_o  = din_s_q & ~din_d_q;
    assign fall_o  = ~din_s_q & din_d_q;
    // On an edge strobe cnt_q still holds the length of the run that just ended.
    assign width_o = cnt_q;

    always_comb begin
        if (rise_o || fall_o) begin
            run_o = CW'(1);
        end else if (cnt_q >= SAT_C) begin
            run_o = SAT_C;
        end else begin
            run_o = cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 NRZ stream into 24-bit words tagged with their LED index.
// Pulses assert 3 clk cycles after the completing din edge; no backpressure.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = DEF_NUM_LEDS,
    parameter int unsigned BIT_SPLIT = DEF_BIT_SPLIT,
    parameter int unsigned MIN_HIGH  = DEF_MIN_HIGH,
    parameter int unsigned MAX_HIGH  = DEF_MAX_HIGH,
    parameter int unsigned RESET_LOW = DEF_RESET_LOW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        pixel_valid,
    output logic        overflow,
    output logic        frame_done,
    output logic        err
);

    localparam int unsigned   CW      = $clog2(RESET_LOW + 1);
    localparam logic [CW-1:0] MIN_W   = CW'(MIN_HIGH);
    localparam logic [CW-1:0] SPLIT_W = CW'(BIT_SPLIT);
    localparam logic [CW-1:0] STUCK_W = CW'(MAX_HIGH + 1);
    localparam logic [CW-1:0] GAP_W   = CW'(RESET_LOW);

    logic          level;
    logic          rise;
    logic          fall;
    logic [CW-1:0] width;
    logic [CW-1:0] run;

    pulse_width_meter #(
        .SAT (RESET_LOW),
        .CW  (CW)
    ) u_meter (
        .clk     (clk),
        .reset   (reset),
        .din_i   (din),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall),
        .width_o (width),
        .run_o   (run)
    );

    rx_state_e   state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [23:0] rgb_q, rgb_d;
    logic [7:0]  led_q, led_d;
    logic        pv_q, pv_d;
    logic        ov_q, ov_d;
    logic        fd_q, fd_d;
    logic        err_q, err_d;
    logic [23:0] word_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            rgb_q      <= '0;
            led_q      <= '0;
            pv_q       <= 1'b0;
            ov_q       <= 1'b0;
            fd_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            rgb_q      <= rgb_d;
            led_q      <= led_d;
            pv_q       <= pv_d;
            ov_q       <= ov_d;
            fd_q       <= fd_d;
            err_q      <= err_d;
        end
    end

    assign word_next = {shift_q[22:0], (width >= SPLIT_W)};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        rgb_d      = rgb_q;
        led_d      = led_q;
        pv_d       = 1'b0;
        ov_d       = 1'b0;
        fd_d       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            SYNC: begin
                if (!level && run == GAP_W) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (width < MIN_W) begin
                        err_d      = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        state_d    = SYNC;
                    end else begin
                        shift_d = word_next;
                        state_d = LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            rgb_d     = word_next;
                            led_d     = word_cnt_q;
                            if (32'(word_cnt_q) >= NUM_LEDS) begin
                                ov_d = 1'b1;
                            end else begin
                                pv_d = 1'b1;
                            end
                            if (word_cnt_q != 8'hFF) begin
                                word_cnt_d = word_cnt_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (run == STUCK_W) begin
                    // Stuck high: report once, then stay silent until a full latch gap.
                    err_d      = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = SYNC;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (run == GAP_W) begin
                    fd_d       = 1'b1;
                    err_d      = (bit_cnt_q != 5'd0);
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign rgb_data    = rgb_q;
    assign led_num     = led_q;
    assign pixel_valid = pv_q;
    assign overflow    = ov_q;
    assign frame_done  = fd_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised WS2812 stream against a scoreboarded reference model of the decoder.
// Expected events carry the exact cycle they must appear on.
module tb_ws2812_rx;

    localparam int NUM_LEDS  = 7;
    localparam int BIT_SPLIT = 8;
    localparam int MIN_HIGH  = 2;
    localparam int MAX_HIGH  = 18;
    localparam int RESET_LOW = 600;

    localparam logic [3:0] K_PIX = 4'b1000;
    localparam logic [3:0] K_OVF = 4'b0100;
    localparam logic [3:0] K_FD  = 4'b0010;
    localparam logic [3:0] K_ERR = 4'b0001;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        din   = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        pixel_valid;
    logic        overflow;
    logic        frame_done;
    logic        err;

    ws2812_rx #(
        .NUM_LEDS  (NUM_LEDS),
        .BIT_SPLIT (BIT_SPLIT),
        .MIN_HIGH  (MIN_HIGH),
        .MAX_HIGH  (MAX_HIGH),
        .RESET_LOW (RESET_LOW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .rgb_data    (rgb_data),
        .led_num     (led_num),
        .pixel_valid (pixel_valid),
        .overflow    (overflow),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  kind;
        logic [23:0] data;
        logic [7:0]  led;
        longint      at;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state: protocol-level view of the receiver.
    bit          synced    = 0;
    bit          in_frame  = 0;
    int          bits      = 0;
    int          idx       = 0;
    int          acc       = 0;
    logic [23:0] last_data = '0;
    logic [7:0]  last_led  = '0;
    longint      last_fall = 0;

    task automatic expect_ev(input logic [3:0] k, input longint at);
        ev_t e;
        e.kind = k;
        e.data = last_data;
        e.led  = last_led;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic unsync();
        synced   = 0;
        in_frame = 0;
        bits     = 0;
        idx      = 0;
    endtask

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One high pulse of hi cycles followed by lo cycles of low.
    task automatic pulse(input int hi, input int lo);
        longint rise_at;
        longint fall_at;
        @(negedge clk);
        din     = 1'b1;
        rise_at = cyc;
        if (synced && hi > MAX_HIGH) begin
            expect_ev(K_ERR, rise_at + MAX_HIGH + 3);
            unsync();
        end
        repeat (hi) @(negedge clk);
        din     = 1'b0;
        fall_at = cyc;
        if (synced) begin
            if (hi < MIN_HIGH) begin
                expect_ev(K_ERR, fall_at + 3);
                unsync();
            end else begin
                acc      = ((acc * 2) + ((hi >= BIT_SPLIT) ? 1 : 0)) % (1 << 24);
                bits     = bits + 1;
                in_frame = 1;
                if (bits == 24) begin
                    last_data = 24'(acc);
                    last_led  = 8'(idx);
                    expect_ev((idx >= NUM_LEDS) ? K_OVF : K_PIX, fall_at + 3);
                    if (idx < 255) idx = idx + 1;
                    bits = 0;
                end
            end
        end
        last_fall = fall_at;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int mode);
        int hi;
        int lo;
        case (mode)
            0: begin hi = b ? 10 : 5; lo = b ? 5 : 10; end
            1: begin hi = b ? BIT_SPLIT : BIT_SPLIT - 1; lo = 6; end
            default: begin
                hi = b ? $urandom_range(MAX_HIGH, BIT_SPLIT) : $urandom_range(BIT_SPLIT - 1, MIN_HIGH);
                lo = $urandom_range(30, 1);
            end
        endcase
        pulse(hi, lo);
    endtask

    task automatic send_word(input logic [23:0] w, input int mode);
        for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
    endtask

    task automatic send_bits(input int n, input int mode);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)), mode);
    endtask

    task automatic gap();
        if (synced && in_frame) begin
            expect_ev((bits != 0) ? (K_FD | K_ERR) : K_FD, last_fall + RESET_LOW + 2);
        end
        synced   = 1;
        in_frame = 0;
        bits     = 0;
        idx      = 0;
        repeat (RESET_LOW + 20) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb_data"}, rgb_data, 0);
        check({tag, "_led_num"}, led_num, 0);
        check({tag, "_pulses"}, {pixel_valid, overflow, frame_done, err}, 0);
    endtask

    initial begin
        logic [23:0] w;
        int          n;

        fork
            forever begin
                @(negedge clk);
                if (!reset && (pixel_valid || overflow || frame_done || err)) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_pulse: got kind=%b rgb=%h led=%0d at cyc %0d, want no pulse",
                                 {pixel_valid, overflow, frame_done, err}, rgb_data, led_num, cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if ({pixel_valid, overflow, frame_done, err} != e.kind || rgb_data != e.data ||
                            led_num != e.led || cyc != e.at) begin
                            n_bad++;
                            $display("FAIL event: got kind=%b rgb=%h led=%0d cyc=%0d, want kind=%b rgb=%h led=%0d cyc=%0d",
                                     {pixel_valid, overflow, frame_done, err}, rgb_data, led_num, cyc,
                                     e.kind, e.data, e.led, e.at);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        gap();

        // Directed word with nominal timing.
        send_word(24'hA53C0F, 0);
        gap();

        // Full frame of 7, then a second frame restarting at index 0.
        for (int i = 1; i <= 7; i++) send_word(24'(i), 0);
        gap();
        send_word(24'h000008, 2);
        gap();

        // Eight words into a seven-LED frame.
        for (int i = 0; i < 8; i++) send_word(24'($urandom()), 2);
        gap();

        // Threshold widths 7 / 8.
        send_word(24'h5AC396, 1);
        gap();

        // Glitch mid-word: remaining traffic ignored until a gap.
        send_bits(3, 2);
        pulse(1, 10);
        send_word(24'($urandom()), 2);
        gap();
        send_word(24'($urandom()), 2);
        gap();

        // Partial word at the latch gap.
        send_bits(10, 2);
        gap();
        send_word(24'($urandom()), 2);
        gap();

        // Stuck high mid-word.
        send_bits(5, 2);
        pulse(40, 8);
        send_bits(7, 2);
        gap();
        send_word(24'($urandom()), 2);
        gap();

        // Reset in the middle of a word.
        send_bits(12, 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        unsync();
        last_data = '0;
        last_led  = '0;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        gap();
        send_word(24'($urandom()), 2);
        gap();

        // Random frames.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(9, 1);
            for (int i = 0; i < n; i++) begin
                w = 24'($urandom());
                send_word(w, 2);
            end
            gap();
        end

        repeat (10) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
